// File: rtl/rom_loader.sv
// rom_loader: routes HPS ioctl download bytes into four ROM regions through a
// 4-entry FIFO, with throttling, error tracking and side-band config capture.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to build the program checksum.
module rom_loader #(
    parameter logic [26:0] REG1_BASE = 27'h0C000,
    parameter logic [26:0] REG2_BASE = 27'h0E000,
    parameter logic [26:0] REG3_BASE = 27'h10000,
    parameter logic [26:0] LOAD_END  = 27'h10100
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [1:0]  mem_region,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_busy,
    output logic        rom_ready,
    output logic        load_err,
    output logic [7:0]  game_id,
    output logic [7:0]  dsw1,
    output logic [7:0]  dsw2,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t      state, state_next;
    logic        dl_q;
    logic        rom_start;
    logic        start;

    logic [1:0]  region_sel;
    logic [15:0] base;
    logic        in_range;
    logic [15:0] rel_addr;

    logic [25:0] fifo_mem [4];
    logic [1:0]  wr_q, rd_q, wr_base, rd_base;
    logic [2:0]  count_q, count_base, count_next;
    logic        rom_wr, push, pop, drop;
    logic [25:0] head;

    logic [1:0]  hold_region;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;

    logic [7:0]  game_id_q = 8'h00;
    logic [7:0]  dsw1_q    = 8'h00;
    logic [7:0]  dsw2_q    = 8'h00;

    logic        unused_bits;
    assign unused_bits = ^ioctl_dout[15:8];

    assign rom_start = ioctl_download && !dl_q && (ioctl_index == 8'd0);
    assign rom_wr    = ioctl_download && ioctl_wr && (ioctl_index == 8'd0);

    // Next-state logic of the download sequencer
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (rom_start) state_next = S_LOAD;
            S_LOAD:  if (!ioctl_download) state_next = S_FLUSH;
            S_FLUSH: if (count_q == 3'd0) state_next = S_DONE;
            S_DONE:  if (rom_start) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    // A new load empties the FIFO; a byte arriving on that same cycle lands in slot 0
    assign start      = (state_next == S_LOAD) && (state != S_LOAD);
    assign wr_base    = start ? 2'd0 : wr_q;
    assign rd_base    = start ? 2'd0 : rd_q;
    assign count_base = start ? 3'd0 : count_q;

    // Region decode; relative address is only needed modulo 2^16
    always_comb begin
        region_sel = 2'd0;
        base       = 16'h0000;
        in_range   = 1'b1;
        if (ioctl_addr < REG1_BASE) begin
            region_sel = 2'd0;
            base       = 16'h0000;
        end else if (ioctl_addr < REG2_BASE) begin
            region_sel = 2'd1;
            base       = REG1_BASE[15:0];
        end else if (ioctl_addr < REG3_BASE) begin
            region_sel = 2'd2;
            base       = REG2_BASE[15:0];
        end else if (ioctl_addr < LOAD_END) begin
            region_sel = 2'd3;
            base       = REG3_BASE[15:0];
        end else begin
            in_range   = 1'b0;
        end
    end

    assign rel_addr   = ioctl_addr[15:0] - base;
    assign pop        = !start && (count_q != 3'd0) && !mem_busy;
    assign push       = rom_wr && in_range && ((count_base != 3'd4) || pop);
    assign drop       = rom_wr && !push;
    assign count_next = count_base + {2'b00, push} - {2'b00, pop};
    assign head       = fifo_mem[rd_q];

    // Drain path: head goes straight out when the memories are free
    assign mem_we     = pop;
    assign mem_region = pop ? head[25:24] : hold_region;
    assign mem_addr   = pop ? head[23:8]  : hold_addr;
    assign mem_data   = pop ? head[7:0]   : hold_data;
    assign rom_ready  = (state == S_DONE);

    // Sequencer state and download-edge history
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            dl_q  <= 1'b0;
        end else begin
            state <= state_next;
            dl_q  <= ioctl_download;
        end
    end

    // FIFO pointers, occupancy, throttle and sticky error
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_q       <= 2'd0;
            rd_q       <= 2'd0;
            count_q    <= 3'd0;
            ioctl_wait <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            wr_q       <= wr_base + 2'(push);
            rd_q       <= rd_base + 2'(pop);
            count_q    <= count_next;
            ioctl_wait <= (count_next >= 3'd2);
            load_err   <= start ? drop : (load_err | drop);
        end
    end

    // FIFO storage: {region, relative address, data}
    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_base] <= {region_sel, rel_addr, ioctl_dout[7:0]};
    end

    // Keep the last written entry visible between write strobes
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_region <= 2'd0;
            hold_addr   <= 16'h0000;
            hold_data   <= 8'h00;
        end else if (pop) begin
            hold_region <= head[25:24];
            hold_addr   <= head[23:8];
            hold_data   <= head[7:0];
        end
    end

    // Side-band game id and DIP switches survive reset
    always_ff @(posedge clk_sys) begin
        if (ioctl_download && ioctl_wr) begin
            if (ioctl_index == 8'd1) game_id_q <= ioctl_dout[7:0];
            if (ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0) begin
                if (ioctl_addr[2:0] == 3'd0) dsw1_q <= ioctl_dout[7:0];
                if (ioctl_addr[2:0] == 3'd1) dsw2_q <= ioctl_dout[7:0];
            end
        end
    end

    assign game_id = game_id_q;
    assign dsw1    = dsw1_q;
    assign dsw2    = dsw2_q;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Wrapping byte sum of bytes accepted during the current load
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_q <= 16'h0000;
        end else if (push) begin
            sum_q <= (start ? 16'h0000 : sum_q) + {8'h00, ioctl_dout[7:0]};
        end else if (start) begin
            sum_q <= 16'h0000;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven vectors plus directed multi-cycle sequences for rom_loader.
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = 27'd0;
    logic [15:0] ioctl_dout = 16'd0;
    logic        ioctl_wait;
    logic [1:0]  mem_region;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_busy = 1'b0;
    logic        rom_ready;
    logic        load_err;
    logic [7:0]  game_id;
    logic [7:0]  dsw1;
    logic [7:0]  dsw2;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;

    rom_loader dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem_region(mem_region), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .mem_busy(mem_busy),
        .rom_ready(rom_ready), .load_err(load_err), .game_id(game_id),
        .dsw1(dsw1), .dsw2(dsw2), .checksum(checksum)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [26:0] addr;
        logic [7:0]  dout;
        logic        busy;
        logic        we;
        logic [1:0]  rgn;
        logic [15:0] maddr;
        logic [7:0]  mdata;
        logic        wt;
        logic        rdy;
        logic        err;
    } vec_t;

    function automatic vec_t mk(logic dl, logic wr, logic [26:0] addr, logic [7:0] dout,
                                logic we, logic [1:0] rgn, logic [15:0] maddr,
                                logic [7:0] mdata, logic rdy, logic err);
        vec_t v;
        v.dl = dl; v.idx = 8'd0; v.wr = wr; v.addr = addr; v.dout = dout; v.busy = 1'b0;
        v.we = we; v.rgn = rgn; v.maddr = maddr; v.mdata = mdata; v.wt = 1'b0;
        v.rdy = rdy; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rom_write(input logic [26:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = {8'h00, d};
        tick();
        ioctl_wr   = 1'b0;
    endtask

    vec_t vecs[14];
    int   pulses;
    logic [7:0] exp_cs;

    initial begin
        vecs[0]  = mk(1, 0, 27'h00000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
        vecs[1]  = mk(1, 1, 27'h00000, 8'h11, 1, 0, 16'h0000, 8'h11, 0, 0);
        vecs[2]  = mk(1, 1, 27'h00001, 8'h22, 1, 0, 16'h0001, 8'h22, 0, 0);
        vecs[3]  = mk(1, 1, 27'h00002, 8'h33, 1, 0, 16'h0002, 8'h33, 0, 0);
        vecs[4]  = mk(1, 1, 27'h00003, 8'h44, 1, 0, 16'h0003, 8'h44, 0, 0);
        vecs[5]  = mk(1, 0, 27'h00000, 8'h00, 0, 0, 16'h0003, 8'h44, 0, 0);
        vecs[6]  = mk(0, 0, 27'h00000, 8'h00, 0, 0, 16'h0003, 8'h44, 0, 0);
        vecs[7]  = mk(0, 0, 27'h00000, 8'h00, 0, 0, 16'h0003, 8'h44, 1, 0);
        vecs[8]  = mk(1, 0, 27'h00000, 8'h00, 0, 0, 16'h0003, 8'h44, 0, 0);
        vecs[9]  = mk(1, 1, 27'h0C005, 8'hA5, 1, 1, 16'h0005, 8'hA5, 0, 0);
        vecs[10] = mk(1, 1, 27'h10100, 8'h77, 0, 1, 16'h0005, 8'hA5, 0, 1);
        vecs[11] = mk(1, 1, 27'h0E010, 8'h5A, 1, 2, 16'h0010, 8'h5A, 0, 1);
        vecs[12] = mk(1, 1, 27'h100FF, 8'h3C, 1, 3, 16'h00FF, 8'h3C, 0, 1);
        vecs[13] = mk(1, 0, 27'h00000, 8'h00, 0, 3, 16'h00FF, 8'h3C, 0, 1);

        // power-up and reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst.we", mem_we, 0);
        chk("rst.wait", ioctl_wait, 0);
        chk("rst.ready", rom_ready, 0);
        chk("rst.err", load_err, 0);
        chk("rst.addr", {mem_region, mem_addr, mem_data}, 0);
        chk("rst.checksum", checksum, 0);
        chk("pwrup.cfg", {game_id, dsw1, dsw2}, 0);
        reset = 1'b0;
        tick();

        // table: basic download, region decode, out-of-range drop
        for (int i = 0; i < 14; i++) begin
            ioctl_download = vecs[i].dl;
            ioctl_index    = vecs[i].idx;
            ioctl_wr       = vecs[i].wr;
            ioctl_addr     = vecs[i].addr;
            ioctl_dout     = {8'h00, vecs[i].dout};
            mem_busy       = vecs[i].busy;
            tick();
            chk($sformatf("v%0d.we", i), mem_we, vecs[i].we);
            chk($sformatf("v%0d.region", i), mem_region, vecs[i].rgn);
            chk($sformatf("v%0d.addr", i), mem_addr, vecs[i].maddr);
            chk($sformatf("v%0d.data", i), mem_data, vecs[i].mdata);
            chk($sformatf("v%0d.wait", i), ioctl_wait, vecs[i].wt);
            chk($sformatf("v%0d.ready", i), rom_ready, vecs[i].rdy);
            chk($sformatf("v%0d.err", i), load_err, vecs[i].err);
        end
        ioctl_wr = 1'b0;

        // finish this load, then start a fresh one which clears load_err
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("reload.ready_done", rom_ready, 1);
        ioctl_download = 1'b1;
        tick();
        chk("reload.ready", rom_ready, 0);
        chk("reload.err_clear", load_err, 0);

        // busy memories: throttle, overflow drop, then drain exactly four
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rom_write(27'h00100 + 27'(i), 8'(i + 1));
            chk($sformatf("busy.we%0d", i), mem_we, 0);
            if (i == 0) chk("busy.wait_after1", ioctl_wait, 0);
            if (i == 1) chk("busy.wait_after2", ioctl_wait, 1);
            if (i == 3) chk("busy.err_before_full", load_err, 0);
        end
        chk("busy.err_overflow", load_err, 1);
        chk("busy.wait_full", ioctl_wait, 1);
        mem_busy = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_sys);
            if (mem_we) begin
                chk($sformatf("drain.addr%0d", pulses), mem_addr, 16'h0100 + 16'(pulses));
                chk($sformatf("drain.data%0d", pulses), mem_data, 8'(pulses + 1));
                pulses++;
            end
            tick();
        end
        chk("drain.pulses", pulses, 4);
        chk("drain.wait", ioctl_wait, 0);

        // reset with three entries pending
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) rom_write(27'h00200 + 27'(i), 8'hA0 + 8'(i));
        chk("pend.wait", ioctl_wait, 1);
        mem_busy = 1'b0;
        @(negedge clk_sys);
        chk("pend.we_before_reset", mem_we, 1);
        chk("pend.addr_before_reset", mem_addr, 16'h0200);
        reset = 1'b1;
        #1;
        chk("midrst.we", mem_we, 0);
        chk("midrst.wait", ioctl_wait, 0);
        chk("midrst.ready", rom_ready, 0);
        chk("midrst.outs", {mem_region, mem_addr, mem_data}, 0);
        chk("midrst.checksum", checksum, 0);
        @(negedge clk_sys);
        reset = 1'b0;
        ioctl_download = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_sys);
            if (mem_we) pulses++;
        end
        chk("midrst.no_more_we", pulses, 0);
        chk("midrst.stays_idle", rom_ready, 0);
        tick();

        // side-band config bytes and their reset immunity
        ioctl_download = 1'b1;
        ioctl_index    = 8'd254;
        tick();
        rom_write(27'd0, 8'h3C);
        rom_write(27'd1, 8'h81);
        rom_write(27'd8, 8'hFF);
        tick();
        chk("dsw.dsw1", dsw1, 8'h3C);
        chk("dsw.dsw2", dsw2, 8'h81);
        chk("dsw.no_fifo", mem_we, 0);
        ioctl_index = 8'd1;
        ioctl_wr    = 1'b1;
        ioctl_addr  = 27'd0;
        ioctl_dout  = 16'h1204;
        tick();
        ioctl_wr = 1'b0;
        chk("gid.value", game_id, 8'h04);
        chk("gid.not_ready", rom_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("cfg.retained", {game_id, dsw1, dsw2}, {8'h04, 8'h3C, 8'h81});
        ioctl_download = 1'b0;
        tick();

        // checksum over FF,FF,02
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        rom_write(27'd0, 8'hFF);
        rom_write(27'd1, 8'hFF);
        rom_write(27'd2, 8'h02);
        tick();
`ifdef ROM_LOADER_CHECKSUM_EN
        exp_cs = 8'h02;
        chk("cs.sum", checksum, {exp_cs, 8'h00});
`else
        exp_cs = 8'h00;
        chk("cs.sum", checksum, {exp_cs, 8'h00});
`endif
        chk("cs.last_data", mem_data, 8'h02);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("cs.ready", rom_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
